// File: rtl/packer_defs.sv
// Shared widths and pack-FSM state encoding for the nibble packer and its FIFO.
package packer_defs;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO: head is visible on data_o whenever valid_o is high.
module byte_fifo
    import packer_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = BYTE_W
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_pop;
    logic do_push;

    // Pop frees a slot in the same cycle, so push at full is legal when popping.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q < DEPTH_C) | do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/nibble_packer.sv
// Packs nibble pairs into bytes and buffers them in a fall-through FIFO.
//   state    | meaning
//   ST_EMPTY | no nibble held; next accepted nibble goes to hold_q
//   ST_HALF  | one nibble in hold_q, waiting for its partner or a flush
module nibble_packer
    import packer_defs::*;
#(
    parameter int DEPTH      = 4,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                       i_CLOCK,
    input  logic                       i_RESET_N,
    input  logic                       i_NIB_VALID,
    input  logic [NIB_W-1:0]           i_NIB_DATA,
    output logic                       o_NIB_READY,
    input  logic                       i_FLUSH,
    output logic                       o_BYTE_VALID,
    output logic [BYTE_W-1:0]          o_BYTE_DATA,
    input  logic                       i_BYTE_READY,
    output logic                       o_HALF,
    output logic [$clog2(DEPTH):0]     o_COUNT
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    pack_state_t       state_q;
    logic [NIB_W-1:0]  hold_q;

    logic              pop;
    logic              space;
    logic              nib_acc;
    logic              flush_fire;
    logic              push;
    logic [NIB_W-1:0]  pair_nib;
    logic [BYTE_W-1:0] push_data;
    logic [CNT_W-1:0]  fifo_count;

    assign pop         = o_BYTE_VALID & i_BYTE_READY;
    assign space       = (fifo_count < DEPTH_C) | pop;
    assign o_NIB_READY = i_RESET_N & ((state_q == ST_EMPTY) | space);
    assign nib_acc     = i_NIB_VALID & o_NIB_READY;

    // A nibble arriving in HALF wins over a flush; the flush then has nothing to pad.
    assign flush_fire  = (state_q == ST_HALF) & ~nib_acc & i_FLUSH & space;
    assign push        = (state_q == ST_HALF) & (nib_acc | flush_fire);

    always_comb begin
        pair_nib  = nib_acc ? i_NIB_DATA : '0;
        push_data = HIGH_FIRST ? {hold_q, pair_nib} : {pair_nib, hold_q};
    end

    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (nib_acc) begin
                        hold_q  <= i_NIB_DATA;
                        state_q <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (push) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign o_HALF = (state_q == ST_HALF);

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i       (i_CLOCK),
        .rst_n_i     (i_RESET_N),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (o_BYTE_VALID),
        .data_o      (o_BYTE_DATA),
        .count_o     (fifo_count)
    );

    assign o_COUNT = fifo_count;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: expected bytes queued at stimulus time, checked on pop.
module tb_nibble_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nib_valid, flush, byte_ready;
    logic [3:0] nib_data;
    logic       nib_ready, byte_valid, half;
    logic [7:0] byte_data;
    logic [2:0] count;

    logic       lo_valid;
    logic [3:0] lo_data;
    logic       lo_flush, lo_bready;
    logic       lo_ready, lo_bvalid, lo_half;
    logic [7:0] lo_bdata;
    logic [2:0] lo_count;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_packer #(.DEPTH(4), .HIGH_FIRST(1'b1)) u_dut (
        .i_CLOCK(clk), .i_RESET_N(rst_n),
        .i_NIB_VALID(nib_valid), .i_NIB_DATA(nib_data), .o_NIB_READY(nib_ready),
        .i_FLUSH(flush),
        .o_BYTE_VALID(byte_valid), .o_BYTE_DATA(byte_data), .i_BYTE_READY(byte_ready),
        .o_HALF(half), .o_COUNT(count)
    );

    nibble_packer #(.DEPTH(4), .HIGH_FIRST(1'b0)) u_lo (
        .i_CLOCK(clk), .i_RESET_N(rst_n),
        .i_NIB_VALID(lo_valid), .i_NIB_DATA(lo_data), .o_NIB_READY(lo_ready),
        .i_FLUSH(lo_flush),
        .o_BYTE_VALID(lo_bvalid), .o_BYTE_DATA(lo_bdata), .i_BYTE_READY(lo_bready),
        .o_HALF(lo_half), .o_COUNT(lo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        byte_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (count == 3'd0) break;
            step();
        end
        chk("drain_count", 32'(count), 32'd0);
        byte_ready = 1'b0;
    endtask

    // Inputs change at posedge+1, so at negedge a high valid&ready means a pop at the next edge.
    always @(negedge clk) begin
        if (rst_n && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_byte", {24'h0, byte_data}, 32'hFFFF_FFFF);
            end else begin
                chk("byte", 32'(byte_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int         acc;
        int         k;
        logic       rdy;
        logic [7:0] v;

        rst_n = 1'b0; nib_valid = 1'b0; nib_data = 4'h0; flush = 1'b0; byte_ready = 1'b0;
        lo_valid = 1'b0; lo_data = 4'h0; lo_flush = 1'b0; lo_bready = 1'b0;

        step(); step();
        chk("rst_ready", 32'(nib_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_data", 32'(byte_data), 32'h00);
        chk("rst_half", 32'(half), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(nib_ready), 32'd1);

        // basic pair, both polarities
        byte_ready = 1'b1;
        nib_valid = 1'b1; nib_data = 4'h7; lo_valid = 1'b1; lo_data = 4'h7;
        step();
        chk("half_between", 32'(half), 32'd1);
        exp_q.push_back(8'h7C);
        nib_data = 4'hC; lo_data = 4'hC;
        step();
        nib_valid = 1'b0; lo_valid = 1'b0;
        chk("half_after", 32'(half), 32'd0);
        chk("latency_valid", 32'(byte_valid), 32'd1);
        chk("hi_first_data", 32'(byte_data), 32'h7C);
        chk("lo_first_data", 32'(lo_bdata), 32'hC7);
        chk("lo_first_valid", 32'(lo_bvalid), 32'd1);
        step();
        chk("pair_popped", 32'(count), 32'd0);

        // fill with consumer stalled
        byte_ready = 1'b0;
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        acc = 0;
        nib_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            nib_data = 4'(acc + 1);
            rdy = nib_ready;
            step();
            if (rdy) acc++;
        end
        chk("fill_accepted", 32'(acc), 32'd9);
        chk("fill_stall_ready", 32'(nib_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_half", 32'(half), 32'd1);
        byte_ready = 1'b1;
        nib_data = 4'hA;
        #1;
        chk("ready_via_pop", 32'(nib_ready), 32'd1);
        exp_q.push_back(8'h9A);
        step();
        byte_ready = 1'b0; nib_valid = 1'b0;
        chk("push_pop_full_count", 32'(count), 32'd4);
        chk("push_pop_full_half", 32'(half), 32'd0);

        // flush held off by a full FIFO, then completes alongside a pop
        nib_valid = 1'b1; nib_data = 4'hB;
        step();
        nib_valid = 1'b0; flush = 1'b1;
        step(); step();
        chk("flush_blocked_half", 32'(half), 32'd1);
        chk("flush_blocked_count", 32'(count), 32'd4);
        exp_q.push_back(8'hB0);
        byte_ready = 1'b1;
        step();
        byte_ready = 1'b0; flush = 1'b0;
        chk("flush_unblocked_half", 32'(half), 32'd0);
        chk("flush_unblocked_count", 32'(count), 32'd4);
        drain();

        // flush cases
        nib_valid = 1'b1; nib_data = 4'h2;
        step();
        nib_valid = 1'b0; flush = 1'b1;
        exp_q.push_back(8'h20);
        step();
        flush = 1'b0;
        chk("flush_half", 32'(half), 32'd0);
        chk("flush_count", 32'(count), 32'd1);
        chk("flush_data", 32'(byte_data), 32'h20);
        flush = 1'b1;
        step(); step();
        flush = 1'b0;
        chk("flush_empty_noop", 32'(count), 32'd1);
        nib_valid = 1'b1; nib_data = 4'h2;
        step();
        nib_data = 4'h5; flush = 1'b1;
        exp_q.push_back(8'h25);
        step();
        nib_valid = 1'b0; flush = 1'b0;
        chk("flush_with_nib_count", 32'(count), 32'd2);
        step();
        chk("flush_with_nib_noextra", 32'(count), 32'd2);
        nib_valid = 1'b1; nib_data = 4'h3; flush = 1'b1;
        step();
        nib_valid = 1'b0;
        chk("empty_flush_nib_half", 32'(half), 32'd1);
        exp_q.push_back(8'h30);
        step();
        flush = 1'b0;
        chk("empty_flush_nib_done", 32'(half), 32'd0);
        chk("empty_flush_nib_count", 32'(count), 32'd3);
        drain();

        // reset mid-pair
        nib_valid = 1'b1; nib_data = 4'hE;
        step();
        nib_valid = 1'b0;
        chk("pre_reset_half", 32'(half), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_half", 32'(half), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(nib_ready), 32'd1);
        nib_valid = 1'b1; nib_data = 4'h1;
        step();
        nib_data = 4'h2;
        exp_q.push_back(8'h12);
        step();
        nib_valid = 1'b0;
        chk("post_rst_data", 32'(byte_data), 32'h12);
        drain();

        // random stream
        for (int b = 0; b < 8; b++) begin
            v = {4'(2 * b), 4'(2 * b + 1)};
            exp_q.push_back(v);
        end
        k = 0;
        for (int c = 0; c < 2000; c++) begin
            if (k >= 16) break;
            nib_valid  = ($urandom_range(0, 2) != 0);
            nib_data   = 4'(k);
            byte_ready = ($urandom_range(0, 2) == 0);
            #1;
            rdy = nib_valid & nib_ready;
            step();
            if (rdy) k++;
        end
        nib_valid = 1'b0;
        chk("stream_all_sent", 32'(k), 32'd16);
        drain();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Upstream feeder for the byte-wide stages. Accepts a stream of 4-bit nibbles over a valid/ready handshake and concatenates consecutive pairs into bytes. The first nibble goes to the upper half by default. Completed bytes are buffered in a small first-word-fall-through FIFO and presented downstream over a second valid/ready handshake. A flush input zero-pads and emits a dangling half byte.

## Interface
- DEPTH, 4, byte FIFO entries; power of two, ≥ 2
- HIGH_FIRST, 1, 1: byte = {first, second}; 0: byte = {second, first}
- i_CLOCK  in  1  sole clock, rising edge
- i_RESET_N  in  1  asynchronous, active-low reset
- i_NIB_VALID  in  1  nibble offered
- i_NIB_DATA  in  4  nibble value
- o_NIB_READY  out  1  nibble accepted when valid & ready at clock edge
- i_FLUSH  in  1  level request: emit pending half byte, zero-padded
- o_BYTE_VALID  out  1  FIFO non-empty
- o_BYTE_DATA  out  8  FIFO head (fall-through)
- i_BYTE_READY  in  1  byte popped when valid & ready at clock edge
- o_HALF  out  1  one nibble held, waiting for its partner
- o_COUNT  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Pack FSM, two states:
  - EMPTY: an accepted nibble is latched into the hold register; go to HALF.
  - HALF: an accepted nibble completes the byte. The FIFO is written with {hold, nib} (HIGH_FIRST=1) or {nib, hold} (HIGH_FIRST=0); go to EMPTY.
- pop = o_BYTE_VALID & i_BYTE_READY.
- space = (o_COUNT < DEPTH) | pop.
- o_NIB_READY = i_RESET_N & (state == EMPTY | space).
  - Combinational from i_BYTE_READY; no path from i_NIB_VALID.
- Flush:
  - Acts only in HALF, with no nibble accepted that cycle, and space available.
  - Writes the hold nibble padded with 4'h0 in the missing half; go to EMPTY.
  - If a nibble is accepted in HALF the same cycle, the normal pair completes and the flush is a no-op.
  - In EMPTY, flush is a no-op. A nibble accepted in EMPTY with i_FLUSH high still goes to HALF.
  - Flush blocked by a full FIFO stays pending while i_FLUSH is held.
- FIFO:
  - Push and pop in the same cycle are allowed at every occupancy, including full. o_COUNT is unchanged in that case.
  - Pointers wrap modulo DEPTH.
  - Order is strictly preserved.
- No push is ever dropped. A push is attempted only when space is true.

## Timing
- Reset values:
  - FSM = EMPTY, hold = 4'h0, pointers = 0.
  - o_COUNT = 0, o_BYTE_VALID = 0, o_BYTE_DATA = 8'h00, o_HALF = 0.
  - o_NIB_READY = 0 while reset is asserted, 1 from the first cycle after release.
- Latency: second nibble accepted at edge N → byte on o_BYTE_DATA with o_BYTE_VALID = 1 after edge N, i.e. usable at edge N+1. A flush has the same latency.
- Throughput:
  - Input side: one nibble per cycle (one byte per two cycles).
  - Output side: one byte per cycle.
- Reset mid-operation discards the hold nibble and all FIFO contents immediately (asynchronous). The first nibble after release starts a new pair.
- o_HALF and o_COUNT are registered state, updated at the clock edge.

## Structure
- Shared defs file `packer_defs`:
  - NIB_W = 4, BYTE_W = 8
  - state encodings ST_EMPTY = 1'b0, ST_HALF = 1'b1
  - no other typedefs
- Sub-module `byte_fifo`:
  - parameters DEPTH and WIDTH = BYTE_W
  - synchronous first-word-fall-through FIFO with push/pop/count
  - same clock and asynchronous active-low reset
- nibble_packer keeps the FSM, the hold register, and the ready/flush logic.

## Test plan
- HIGH_FIRST=1, i_BYTE_READY=1: nibbles 4'h7, 4'hC → single byte 8'h7C; o_HALF is 1 between the two accepts and 0 after.
- HIGH_FIRST=0: nibbles 4'h7, 4'hC → 8'hC7.
- DEPTH=4, i_BYTE_READY=0, i_NIB_VALID=1 continuously:
  - 9 nibbles accepted (8 fill the FIFO, 9th held).
  - 10th stalls with o_NIB_READY=0 and o_COUNT=4.
  - Raise i_BYTE_READY for one cycle: the 10th nibble is accepted in the same cycle as the pop; o_COUNT stays 4.
- Flush:
  - Nibble 4'h2, then i_FLUSH with no valid → byte 8'h20, o_HALF=0.
  - i_FLUSH in EMPTY → no byte written.
  - i_FLUSH together with nibble 4'h5 in HALF (hold 4'h2) → 8'h25 only.
- Reset mid-pair:
  - Accept 4'hE, assert i_RESET_N=0 for one cycle → o_HALF=0, o_COUNT=0.
  - Then nibbles 4'h1, 4'h2 → 8'h12.
- Stream nibbles 0..F with random valid gaps and random i_BYTE_READY → bytes 01,23,45,67,89,AB,CD,EF in order, none lost or duplicated.
